// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: syncs, blanking, coordinates, line/frame strobes
// and a wrapping frame counter, all registered and aligned with the internal position.
module vga_timing_gen #(
    parameter int H_PIXELS   = 640,
    parameter int H_FP       = 16,
    parameter int H_PULSE    = 96,
    parameter int H_BP       = 48,
    parameter int V_PIXELS   = 480,
    parameter int V_FP       = 10,
    parameter int V_PULSE    = 2,
    parameter int V_BP       = 33,
    parameter int H_POL      = 0,
    parameter int V_POL      = 0,
    parameter int H_BITS     = 10,
    parameter int V_BITS     = 10,
    parameter int FRAME_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pix_en,
    output logic                  h_sync,
    output logic                  v_sync,
    output logic                  n_sync,
    output logic                  disp_ena,
    output logic                  n_blank,
    output logic [H_BITS-1:0]     col,
    output logic [V_BITS-1:0]     row,
    output logic                  line_start,
    output logic                  frame_start,
    output logic [FRAME_BITS-1:0] frame_cnt
);

    localparam int H_TOTAL = H_PIXELS + H_FP + H_PULSE + H_BP;
    localparam int V_TOTAL = V_PIXELS + V_FP + V_PULSE + V_BP;

    if (H_PIXELS < 1 || H_FP < 1 || H_PULSE < 1 || H_BP < 1) begin : g_bad_h_region
        $error("vga_timing_gen: every horizontal region must be at least one clock");
    end
    if (V_PIXELS < 1 || V_FP < 1 || V_PULSE < 1 || V_BP < 1) begin : g_bad_v_region
        $error("vga_timing_gen: every vertical region must be at least one line");
    end
    if (H_BITS < 2 || (H_TOTAL - 1) >= (2 ** H_BITS)) begin : g_bad_h_bits
        $error("vga_timing_gen: H_BITS cannot hold H_TOTAL-1");
    end
    if (V_BITS < 2 || (V_TOTAL - 1) >= (2 ** V_BITS)) begin : g_bad_v_bits
        $error("vga_timing_gen: V_BITS cannot hold V_TOTAL-1");
    end

    localparam logic [H_BITS-1:0] H_ZERO     = {H_BITS{1'b0}};
    localparam logic [H_BITS-1:0] H_ONE      = {{(H_BITS-1){1'b0}}, 1'b1};
    localparam logic [H_BITS-1:0] H_LAST     = H_BITS'(H_TOTAL - 1);
    localparam logic [H_BITS-1:0] H_ACT      = H_BITS'(H_PIXELS);
    localparam logic [H_BITS-1:0] H_SYNC_BEG = H_BITS'(H_PIXELS + H_FP);
    localparam logic [H_BITS-1:0] H_SYNC_END = H_BITS'(H_PIXELS + H_FP + H_PULSE);
    localparam logic [V_BITS-1:0] V_ZERO     = {V_BITS{1'b0}};
    localparam logic [V_BITS-1:0] V_ONE      = {{(V_BITS-1){1'b0}}, 1'b1};
    localparam logic [V_BITS-1:0] V_LAST     = V_BITS'(V_TOTAL - 1);
    localparam logic [V_BITS-1:0] V_ACT      = V_BITS'(V_PIXELS);
    localparam logic [V_BITS-1:0] V_SYNC_BEG = V_BITS'(V_PIXELS + V_FP);
    localparam logic [V_BITS-1:0] V_SYNC_END = V_BITS'(V_PIXELS + V_FP + V_PULSE);
    localparam logic [FRAME_BITS-1:0] F_ZERO = {FRAME_BITS{1'b0}};
    localparam logic [FRAME_BITS-1:0] F_ONE  = {{(FRAME_BITS-1){1'b0}}, 1'b1};
    localparam logic H_LVL = 1'(H_POL);
    localparam logic V_LVL = 1'(V_POL);

    logic [H_BITS-1:0]     h_r;
    logic [V_BITS-1:0]     v_r;
    logic [H_BITS-1:0]     h_nxt_s;
    logic [V_BITS-1:0]     v_nxt_s;
    logic                  h_in_sync_s;
    logic                  v_in_sync_s;
    logic                  active_s;
    logic                  line_start_s;
    logic                  frame_start_s;
    logic [H_BITS-1:0]     col_s;
    logic [V_BITS-1:0]     row_s;
    logic                  h_sync_r;
    logic                  v_sync_r;
    logic                  n_sync_r;
    logic                  disp_ena_r;
    logic [H_BITS-1:0]     col_r;
    logic [V_BITS-1:0]     row_r;
    logic                  line_start_r;
    logic                  frame_start_r;
    logic [FRAME_BITS-1:0] frame_cnt_r;

    // Next raster position: advance only on pix_en, wrapping line then frame.
    always_comb begin
        h_nxt_s = h_r;
        v_nxt_s = v_r;
        if (pix_en) begin
            if (h_r == H_LAST) begin
                h_nxt_s = H_ZERO;
                if (v_r == V_LAST) begin
                    v_nxt_s = V_ZERO;
                end else begin
                    v_nxt_s = v_r + V_ONE;
                end
            end else begin
                h_nxt_s = h_r + H_ONE;
            end
        end else begin
            h_nxt_s = h_r;
            v_nxt_s = v_r;
        end
    end

    // Decode the next position so registered outputs line up with the position register.
    always_comb begin
        h_in_sync_s   = (h_nxt_s >= H_SYNC_BEG) && (h_nxt_s < H_SYNC_END);
        v_in_sync_s   = (v_nxt_s >= V_SYNC_BEG) && (v_nxt_s < V_SYNC_END);
        active_s      = (h_nxt_s < H_ACT) && (v_nxt_s < V_ACT);
        col_s         = (h_nxt_s < H_ACT) ? h_nxt_s : H_ZERO;
        row_s         = (v_nxt_s < V_ACT) ? v_nxt_s : V_ZERO;
        // Strobes are gated by pix_en so a held position never re-fires them.
        line_start_s  = pix_en && (h_nxt_s == H_ZERO);
        frame_start_s = line_start_s && (v_nxt_s == V_ZERO);
    end

    // Position and output registers; reset parks on the last back-porch pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_r           <= H_LAST;
            v_r           <= V_LAST;
            h_sync_r      <= ~H_LVL;
            v_sync_r      <= ~V_LVL;
            n_sync_r      <= 1'b1;
            disp_ena_r    <= 1'b0;
            col_r         <= H_ZERO;
            row_r         <= V_ZERO;
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
            frame_cnt_r   <= F_ZERO;
        end else begin
            h_r           <= h_nxt_s;
            v_r           <= v_nxt_s;
            h_sync_r      <= h_in_sync_s ? H_LVL : ~H_LVL;
            v_sync_r      <= v_in_sync_s ? V_LVL : ~V_LVL;
            n_sync_r      <= ~(h_in_sync_s | v_in_sync_s);
            disp_ena_r    <= active_s;
            col_r         <= col_s;
            row_r         <= row_s;
            line_start_r  <= line_start_s;
            frame_start_r <= frame_start_s;
            frame_cnt_r   <= frame_start_s ? (frame_cnt_r + F_ONE) : frame_cnt_r;
        end
    end

    assign h_sync      = h_sync_r;
    assign v_sync      = v_sync_r;
    assign n_sync      = n_sync_r;
    assign disp_ena    = disp_ena_r;
    assign n_blank     = disp_ena_r;
    assign col         = col_r;
    assign row         = row_r;
    assign line_start  = line_start_r;
    assign frame_start = frame_start_r;
    assign frame_cnt   = frame_cnt_r;

endmodule
